// File: rtl/io_output.sv
// Output byte device for the subleq machine: queues the low byte of each CPU
// word in a small FIFO and hands it to a byte sink over valid/ready.
module io_output #(
  parameter int unsigned WORD_SIZE       = 16,
  parameter int unsigned DEPTH           = 8,
  parameter bit          EOS_ON_NEGATIVE = 1'b1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 out_write,
  input  logic [WORD_SIZE-1:0] io_out,
  output logic                 out_full,
  output logic                 out_valid,
  output logic [7:0]           out_byte,
  input  logic                 out_ready,
  output logic                 out_done,
  output logic                 overflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [7:0]        byte_next;
  logic              closed;
  logic              is_full;
  logic              marker;
  logic              reject;
  logic              push;
  logic              eos_set;
  logic              pop;
  logic              unused_bits;

  // Only the low byte and (optionally) the sign bit carry meaning.
  assign unused_bits = ^io_out;

  // Accept/reject decisions and the next head-of-queue byte.
  always_comb begin
    is_full    = (count == CNT_W'(DEPTH));
    marker     = EOS_ON_NEGATIVE && io_out[WORD_SIZE-1];
    reject     = out_write && (is_full || closed);
    push       = out_write && !reject && !marker;
    eos_set    = out_write && !reject && marker;
    pop        = out_valid && out_ready;
    rd_next    = pop ? ADDR_W'(rd_ptr + 1'b1) : rd_ptr;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = CNT_W'(count + 1'b1);
      2'b01:   count_next = CNT_W'(count - 1'b1);
      default: count_next = count;
    endcase
    byte_next = 8'h00;
    if (count_next != '0) begin
      // Queue empty after this cycle's pop: the incoming byte becomes the head.
      if (push && (count == CNT_W'(pop)))
        byte_next = io_out[7:0];
      else
        byte_next = mem[rd_next];
    end
  end

  // Storage is not reset; the cleared count makes stale contents invisible.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= io_out[7:0];
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      closed    <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_full  <= 1'b0;
      out_done  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= ADDR_W'(wr_ptr + 1'b1);
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      out_byte  <= byte_next;
      out_full  <= (count_next == CNT_W'(DEPTH));
      if (eos_set)
        closed <= 1'b1;
      if (reject)
        overflow <= 1'b1;
      if (closed && (count == '0))
        out_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_output.sv
// Randomized and directed bench for io_output against a queue-based model.
module tb_io_output;

  localparam int unsigned WS    = 16;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          areset;
  logic          out_write;
  logic [WS-1:0] io_out;
  logic          out_full;
  logic          out_valid;
  logic [7:0]    out_byte;
  logic          out_ready;
  logic          out_done;
  logic          overflow;

  logic          w2;
  logic [WS-1:0] d2;
  logic          full2;
  logic          valid2;
  logic [7:0]    byte2;
  logic          done2;
  logic          ovf2;

  int checks = 0;
  int errors = 0;

  byte unsigned q[$];
  bit m_closed;
  bit m_done;
  bit m_ovf;

  always #5 clk = ~clk;

  io_output #(.WORD_SIZE(WS), .DEPTH(DEPTH), .EOS_ON_NEGATIVE(1'b1)) dut (
    .clk(clk), .areset(areset), .out_write(out_write), .io_out(io_out),
    .out_full(out_full), .out_valid(out_valid), .out_byte(out_byte),
    .out_ready(out_ready), .out_done(out_done), .overflow(overflow)
  );

  io_output #(.WORD_SIZE(WS), .DEPTH(DEPTH), .EOS_ON_NEGATIVE(1'b0)) dut_raw (
    .clk(clk), .areset(areset), .out_write(w2), .io_out(d2),
    .out_full(full2), .out_valid(valid2), .out_byte(byte2),
    .out_ready(1'b1), .out_done(done2), .overflow(ovf2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check_eq("out_byte", 32'(out_byte), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check_eq("out_full", 32'(out_full), 32'(q.size() == DEPTH));
    check_eq("out_done", 32'(out_done), 32'(m_done));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic model_update(input bit w, input logic [WS-1:0] d, input bit r, input bit rst);
    bit do_pop;
    bit do_push;
    bit done_n;
    if (rst) begin
      q.delete();
      m_closed = 1'b0;
      m_done   = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      do_pop  = (q.size() != 0) && r;
      do_push = 1'b0;
      done_n  = m_done || (m_closed && q.size() == 0);
      if (w) begin
        if (q.size() == DEPTH || m_closed) m_ovf = 1'b1;
        else if (d[WS-1])                  m_closed = 1'b1;
        else                               do_push = 1'b1;
      end
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d[7:0]);
      m_done = done_n;
    end
  endtask

  // One clock cycle: check outputs, apply inputs, advance the model.
  task automatic step(input bit w, input logic [WS-1:0] d, input bit r, input bit rst);
    compare_all();
    out_write = w;
    io_out    = d;
    out_ready = r;
    areset    = rst;
    @(posedge clk);
    model_update(w, d, r, rst);
    @(negedge clk);
  endtask

  initial begin
    areset = 1'b1; out_write = 1'b0; io_out = '0; out_ready = 1'b0;
    w2 = 1'b0; d2 = '0;
    @(posedge clk);
    model_update(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    areset = 1'b0;

    // Back-to-back writes with the sink ready.
    step(1'b1, 16'h0048, 1'b1, 1'b0);
    step(1'b1, 16'h0069, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Fill past capacity, then drain.
    for (int i = 0; i < 9; i++) step(1'b1, WS'(16'h0041 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Held byte under backpressure.
    step(1'b1, 16'h005A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Streaming with pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b1, WS'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);

    // End-of-stream marker followed by a rejected write.
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 16'h0031, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 16'h0032, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-stream, then normal operation resumes.
    for (int i = 0; i < 3; i++) step(1'b1, WS'(16'h0070 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0021, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with rare markers and resets.
    for (int i = 0; i < 400; i++) begin
      logic [WS-1:0] d;
      d = WS'($urandom());
      if ($urandom_range(0, 59) != 0) d[WS-1] = 1'b0;
      step(1'(($urandom_range(0, 2)) != 0), d, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 79) == 0));
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Instance without end-of-stream: negative words are plain data.
    out_write = 1'b0; out_ready = 1'b1;
    w2 = 1'b1; d2 = 16'hFFC3;
    @(posedge clk); @(negedge clk);
    w2 = 1'b0;
    check_eq("raw_valid", 32'(valid2), 32'h1);
    check_eq("raw_byte", 32'(byte2), 32'hC3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
    end
    check_eq("raw_valid_after", 32'(valid2), 32'h0);
    check_eq("raw_done", 32'(done2), 32'h0);
    check_eq("raw_overflow", 32'(ovf2), 32'h0);
    check_eq("raw_full", 32'(full2), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_output.md
Name: io_output

Overview:
- Output-side counterpart of the subleq machine's character input device.
- The CPU's store to the output address pulses `out_write` with a word. The block queues the low byte in a small FIFO and presents it to a byte sink (UART transmitter, or simulation printer) over a valid/ready handshake.
- A negative word written by the CPU marks end of stream. The block reports `out_done` once every queued byte has been delivered.

Parameters:
- WORD_SIZE, `WORD_SIZE` (from defines.vh), CPU data word width, minimum 8.
- DEPTH, 8, FIFO depth in bytes; power of two, at least 2.
- EOS_ON_NEGATIVE, 1, when 1 a written word with MSB set is an end-of-stream marker rather than data.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- areset  input  1  reset, synchronous, active-high.
- out_write  input  1  CPU write strobe, one word per asserted cycle.
- io_out  input  WORD_SIZE  word written by CPU.
- out_full  output  1  FIFO holds DEPTH bytes; a CPU write this cycle is rejected.
- out_valid  output  1  out_byte holds a byte for the sink.
- out_byte  output  8  head-of-FIFO byte.
- out_ready  input  1  sink accepts out_byte this cycle.
- out_done  output  1  end of stream seen and FIFO drained; sticky.
- overflow  output  1  sticky error: a write was dropped.

Behaviour:
- Reset, sampled on a clk edge with areset=1:
  - pointers and count cleared, FIFO contents discarded;
  - out_valid=0, out_byte=0, out_full=0, out_done=0, overflow=0, internal closed flag=0.
  - Reset mid-stream drops any undelivered bytes.
- Storage: DEPTH x 8 array, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- Write acceptance: a push occurs iff out_write=1 and count<DEPTH and closed=0, all evaluated at cycle start.
  - Enqueued data is io_out[7:0]; upper bits are ignored.
  - When EOS_ON_NEGATIVE=1 and io_out[WORD_SIZE-1]=1: nothing is enqueued; closed is set.
- Rejected writes: out_write=1 while count==DEPTH, or while closed=1, sets overflow; the word is dropped.
  - The push is rejected even if a pop occurs in the same cycle. out_full is count==DEPTH.
- Output: out_valid = (count!=0). out_byte = mem[rd_ptr] when valid, 0 otherwise.
  - A pop occurs iff out_valid=1 and out_ready=1.
  - out_byte and out_valid are held stable while out_valid=1 and out_ready=0.
- Latency: a byte pushed in cycle N is visible with out_valid=1 in cycle N+1. Minimum write-to-delivery is 1 cycle.
- Simultaneous push and pop at 0<count<DEPTH: count unchanged, both pointers advance, FIFO order preserved.
- Push into an empty FIFO with out_ready=1 in the same cycle: no pop that cycle, because out_valid was 0.
- Throughput: one byte per cycle in each direction when not full and not empty.
- out_done: registered. Becomes 1 the cycle after the block observes closed=1 and count==0. Stays 1 until reset.
  - A marker written to an already-empty FIFO gives out_done two cycles after the write strobe.
- EOS_ON_NEGATIVE=0: every word is data and out_done never asserts.
- out_full, out_done and overflow are registered outputs.

Test Plan:
- Reset, then write 0x0048, 0x0069 in consecutive cycles with out_ready=1 → out_byte 0x48 then 0x69 with out_valid=1 in cycles 1 and 2 after the first write; then out_valid=0; overflow=0.
- DEPTH=8, out_ready=0, write 9 words 0x41..0x49 → out_full=1 after the 8th; the 9th is dropped; overflow=1. Raise out_ready → exactly 0x41..0x48 delivered in order, then out_valid=0.
- Hold out_ready=0 for 5 cycles with one byte 0x5A queued → out_byte stays 0x5A and out_valid stays 1 throughout; delivered once on the cycle out_ready=1.
- Write 0x0031, then 0xFFFF (marker), then 0x0032, out_ready low for 3 cycles → 0x32 dropped with overflow=1. After out_ready=1, 0x31 is delivered, then out_done=1 the following cycle and it remains 1.
- Continuous write and read with out_ready=1 for 20 cycles, data 0..19 → bytes 0..19 delivered one cycle after each write; count never exceeds 1; pointers wrap cleanly past DEPTH.
- Queue 3 bytes, assert areset for one cycle → next cycle out_valid=0, out_full=0, out_done=0, overflow=0. A subsequent write 0x0021 is delivered normally.
